// File: rtl/sq_seq_pkg.sv
// Shared widths, FSM state encoding and pattern-entry layout for the note sequencer.
package sq_seq_pkg;

   localparam int unsigned NOTE_W   = 6;          // note index width, matches sq_channel
   localparam int unsigned STEP_W   = 4;          // log2(STEPS)
   localparam int unsigned STEPS    = 16;         // pattern length, power of two
   localparam int unsigned REST_BIT = NOTE_W;     // rest flag position in a pattern entry
   localparam int unsigned TEMPO_W  = 3;          // tempo field width
   localparam int unsigned BUDGET_W = 4;          // tick budget; tempo+1 fits without overflow

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_LOAD = 2'd2,
      ST_HOLD = 2'd3
   } seq_state_e;

endpackage

// File: rtl/sq_tick_div.sv
// Free-running note clock divider.
//  clk50mhz  in   system clock
//  rst_n     in   synchronous reset, active low
//  note_clk  out  square wave, toggles every CLK_DIV cycles
//  tick_c    out  1-cycle strobe on the wrap where note_clk rises (combinational)
module sq_tick_div
   import sq_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV = 390625
) (
   input  logic clk50mhz,
   input  logic rst_n,
   output logic note_clk,
   output logic tick_c
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] count_q;
   logic             wrap_c;

   assign wrap_c = (count_q == CNT_W'(CLK_DIV - 1));
   // note_clk is still low on the wrap that is about to raise it
   assign tick_c = wrap_c && !note_clk;

   // Counter and note_clk phase; only rst_n ever realigns them
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         count_q  <= '0;
         note_clk <= 1'b0;
      end else if (wrap_c) begin
         count_q  <= '0;
         note_clk <= ~note_clk;
      end else begin
         count_q  <= count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sq_note_sequencer.sv
// 16-step pattern sequencer driving one sq_channel.
//  clk50mhz  in   system clock
//  rst_n     in   synchronous reset, active low
//  start     in   pulse: begin playback at step 0 (ignored while busy or with stop)
//  stop      in   pulse: abort playback, no done
//  loop_en   in   wrap to step 0 after the last step, sampled at that boundary
//  tempo     in   step length in ticks minus one, sampled in LOAD
//  wr_en/wr_addr/wr_data in  pattern write port, {rest, note}
//  note_clk  out  square clock to sq_channel
//  note_in   out  current note
//  note_rst  out  envelope retrigger / silence
//  step_idx  out  step currently playing
//  busy      out  high while not idle
//  done      out  pulse when a one-shot pattern completes
module sq_note_sequencer
   import sq_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV = 390625
) (
   input  logic                clk50mhz,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                loop_en,
   input  logic [TEMPO_W-1:0]  tempo,
   input  logic                wr_en,
   input  logic [STEP_W-1:0]   wr_addr,
   input  logic [NOTE_W:0]     wr_data,
   output logic                note_clk,
   output logic [NOTE_W-1:0]   note_in,
   output logic                note_rst,
   output logic [STEP_W-1:0]   step_idx,
   output logic                busy,
   output logic                done
);

   logic tick_c;

   sq_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk50mhz (clk50mhz),
      .rst_n    (rst_n),
      .note_clk (note_clk),
      .tick_c   (tick_c)
   );

   logic [NOTE_W:0]     pat_q [STEPS];
   seq_state_e          state_q, state_d;
   logic [BUDGET_W-1:0] budget_q, budget_d;
   logic                rest_q, rest_d;
   logic [NOTE_W-1:0]   note_d;
   logic                note_rst_d, busy_d, done_d;
   logic [STEP_W-1:0]   step_d;
   logic                cur_rest_c;
   logic [NOTE_W-1:0]   cur_note_c;

   // LOAD reads the pre-write contents when a write hits the same step
   assign cur_rest_c = pat_q[step_idx][REST_BIT];
   assign cur_note_c = pat_q[step_idx][NOTE_W-1:0];

   // Pattern register file
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(STEPS); i++) pat_q[i] <= '0;
      end else if (wr_en) begin
         pat_q[wr_addr] <= wr_data;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk50mhz) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         budget_q <= '0;
         rest_q   <= 1'b0;
         note_in  <= '0;
         note_rst <= 1'b0;
         step_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         budget_q <= budget_d;
         rest_q   <= rest_d;
         note_in  <= note_d;
         note_rst <= note_rst_d;
         step_idx <= step_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      budget_d   = budget_q;
      rest_d     = rest_q;
      note_d     = note_in;
      note_rst_d = note_rst;
      step_d     = step_idx;
      busy_d     = busy;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_ARM;
               step_d  = '0;
               busy_d  = 1'b1;
            end
         end
         ST_ARM: begin
            if (tick_c) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!cur_rest_c) note_d = cur_note_c;
            rest_d     = cur_rest_c;
            budget_d   = BUDGET_W'(tempo) + BUDGET_W'(1);
            note_rst_d = 1'b1;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (tick_c) begin
               budget_d = budget_q - BUDGET_W'(1);
               // rest steps keep the channel silenced until the step ends
               if (!rest_q) note_rst_d = 1'b0;
               if (budget_q == BUDGET_W'(1)) begin
                  note_rst_d = 1'b0;
                  if (step_idx != STEP_W'(STEPS - 1)) begin
                     step_d  = step_idx + STEP_W'(1);
                     state_d = ST_LOAD;
                  end else if (loop_en) begin
                     step_d  = '0;
                     state_d = ST_LOAD;
                  end else begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // stop overrides everything, including a same-cycle completion
      if (stop && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         busy_d     = 1'b0;
         note_rst_d = 1'b0;
         done_d     = 1'b0;
      end
   end

endmodule

// File: tb/tb_sq_note_sequencer.sv
module tb_sq_note_sequencer;

   logic       clk50mhz = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
   logic [2:0] tempo = '0;
   logic [3:0] wr_addr = '0;
   logic [6:0] wr_data = '0;
   logic       note_clk, note_rst, busy, done;
   logic [5:0] note_in;
   logic [3:0] step_idx;

   sq_note_sequencer #(.CLK_DIV(4)) dut (
      .clk50mhz (clk50mhz), .rst_n (rst_n), .start (start), .stop (stop),
      .loop_en (loop_en), .tempo (tempo), .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_data (wr_data), .note_clk (note_clk), .note_in (note_in),
      .note_rst (note_rst), .step_idx (step_idx), .busy (busy), .done (done)
   );

   always #5 clk50mhz = ~clk50mhz;

   typedef struct {
      bit is_done;
      int idx;
      int note;
      int gap;   // cycles since previous step start, 0 = not checked
      int hi;    // cycles note_rst stays high in this step
   } exp_t;

   exp_t       q[$];
   logic [6:0] pat_m [16];
   int         cur_note_m = 0;
   int         total = 0, bad = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: what playing n steps from 'first' must look like
   task automatic push_run(input int first, input int n, input int t, input bit fresh);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         int  idx;
         bit  rest;
         idx  = (first + k) % 16;
         rest = pat_m[idx][6];
         if (!rest) cur_note_m = int'(pat_m[idx][5:0]);
         e.is_done = 1'b0;
         e.idx     = idx;
         e.note    = cur_note_m;
         e.gap     = (fresh && k == 0) ? 0 : 8 * (t + 1);
         e.hi      = rest ? 8 * (t + 1) - 1 : 7;
         q.push_back(e);
      end
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1; e.idx = 0; e.note = 0; e.gap = 0; e.hi = 0;
      q.push_back(e);
   endtask

   // Monitor: compares every step start and every done pulse with the queue
   initial begin : monitor
      int   cyc = 0, last_rise = -1, hi_start = 0, hi_exp = 0;
      logic prev_rst = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk50mhz);
         #1;
         cyc++;
         if (!rst_n) begin
            prev_rst  = 1'b0;
            last_rise = -1;
         end else begin
            if (note_rst && !prev_rst) begin
               if (q.size() == 0) check("unexpected_step_start", 1, 0);
               else begin
                  e = q.pop_front();
                  check("start_is_step", int'(e.is_done), 0);
                  check("step_idx", int'(step_idx), e.idx);
                  check("note_in", int'(note_in), e.note);
                  check("busy_in_step", int'(busy), 1);
                  if (e.gap != 0 && last_rise >= 0) check("step_len", cyc - last_rise, e.gap);
                  hi_exp = e.hi;
               end
               last_rise = cyc;
               hi_start  = cyc;
            end
            if (!note_rst && prev_rst && (busy || done))
               check("note_rst_high_len", cyc - hi_start, hi_exp);
            if (done) begin
               if (q.size() == 0) check("unexpected_done", 1, 0);
               else begin
                  e = q.pop_front();
                  check("done_expected", int'(e.is_done), 1);
                  check("busy_at_done", int'(busy), 0);
               end
               last_rise = -1;
            end
            prev_rst = note_rst;
         end
      end
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk50mhz);
   endtask

   task automatic write(input int a, input logic [6:0] d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      @(negedge clk50mhz);
      wr_en = 1'b0;
      pat_m[a] = d;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk50mhz);
      start = 1'b0;
   endtask

   task automatic wait_step(input int idx, input bit want_rst, input int maxc, input string name);
      int n = 0;
      while (!(busy && int'(step_idx) == idx && note_rst == want_rst) && n < maxc) begin
         @(negedge clk50mhz);
         n++;
      end
      if (n >= maxc) check(name, 0, 1);
   endtask

   task automatic wait_idle(input int maxc, input string name);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk50mhz);
         n++;
      end
      if (n >= maxc) check(name, 0, 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_note_clk"}, int'(note_clk), 0);
      check({tag, "_note_in"}, int'(note_in), 0);
      check({tag, "_note_rst"}, int'(note_rst), 0);
      check({tag, "_step_idx"}, int'(step_idx), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   initial begin : stim
      logic [6:0] d;
      for (int i = 0; i < 16; i++) pat_m[i] = '0;

      // Reset and divider phase
      cyc_n(3);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk50mhz);
         check("note_clk_phase", int'(note_clk), (k / 4) % 2);
      end

      // One-shot, notes 10..25, tempo 0
      for (int i = 0; i < 16; i++) write(i, 7'(i + 10));
      tempo = 3'd0; loop_en = 1'b0;
      push_run(0, 16, 0, 1'b1);
      push_done();
      pulse_start();
      wait_idle(16 * 8 + 40, "oneshot_timeout");
      cyc_n(2);
      check("oneshot_busy_after", int'(busy), 0);

      // Loop with a rest on step 3, tempo 1, stop during step 5 of the second pass
      for (int i = 0; i < 16; i++) write(i, {1'b0, 6'($urandom_range(0, 63))});
      write(3, {1'b1, 6'($urandom_range(0, 63))});
      tempo = 3'd1; loop_en = 1'b1;
      push_run(0, 16, 1, 1'b1);
      push_run(0, 6, 1, 1'b0);
      pulse_start();
      wait_step(15, 1'b1, 16 * 16 + 40, "loop_reach15_timeout");
      wait_step(5, 1'b1, 6 * 16 + 40, "loop_reach5_timeout");
      cyc_n(3);
      stop = 1'b1;
      @(negedge clk50mhz);
      stop = 1'b0;
      check("stop_busy", int'(busy), 0);
      check("stop_note_rst", int'(note_rst), 0);
      check("stop_note_in_held", int'(note_in), cur_note_m);
      check("stop_no_done", int'(done), 0);
      cyc_n(40);
      check("stop_stays_idle", int'(busy), 0);
      check("stop_queue_drained", q.size(), 0);

      // start and stop together from idle
      start = 1'b1; stop = 1'b1;
      @(negedge clk50mhz);
      start = 1'b0; stop = 1'b0;
      check("startstop_busy", int'(busy), 0);
      cyc_n(20);
      check("startstop_still_idle", int'(busy), 0);

      // Write to step 2 in its own LOAD cycle
      for (int i = 0; i < 16; i++) write(i, {1'b0, 6'($urandom_range(0, 63))});
      tempo = 3'd0; loop_en = 1'b1;
      push_run(0, 16, 0, 1'b1);
      pulse_start();
      wait_step(2, 1'b0, 4 * 8 + 40, "hazard_load_timeout");
      d = {1'b0, pat_m[2][5:0] ^ 6'h2a};
      write(2, d);
      push_run(0, 16, 0, 1'b0);
      push_done();
      wait_step(15, 1'b1, 16 * 8 + 40, "hazard_pass1_timeout");
      wait_step(0, 1'b1, 3 * 8 + 20, "hazard_pass2_timeout");
      loop_en = 1'b0;
      wait_idle(16 * 8 + 40, "hazard_end_timeout");

      // Reset during play clears everything, including the pattern
      tempo = 3'd2;
      push_run(0, 1, 2, 1'b1);
      pulse_start();
      wait_step(0, 1'b1, 40, "rstplay_timeout");
      cyc_n(5);
      rst_n = 1'b0;
      cyc_n(2);
      check_zero_outputs("midreset");
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) pat_m[i] = '0;
      cur_note_m = 0;
      tempo = 3'd0; loop_en = 1'b0;
      push_run(0, 16, 0, 1'b1);
      push_done();
      pulse_start();
      wait_idle(16 * 8 + 40, "after_reset_timeout");

      // Random patterns, rests and tempos
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++)
            write(i, {($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63))});
         tempo = 3'($urandom_range(0, 7)); loop_en = 1'b0;
         push_run(0, 16, int'(tempo), 1'b1);
         push_done();
         pulse_start();
         wait_idle(16 * 64 + 40, "random_timeout");
         cyc_n(2);
      end

      cyc_n(5);
      check("final_queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
